// File: rtl/pe_mux_pkg.sv
// Shared definitions for the pipelined PE-array element selector:
// select-width sizing, the per-lane element extract helper and the counter width.
package pe_mux_pkg;

  localparam int BEAT_CNT_W = 16;

  // Upper bounds the extract helper is sized for; instances must stay within them
  // (NUM_PES <= MAX_PES and DATA_TYPE < MAX_DW).
  localparam int MAX_PES = 64;
  localparam int MAX_DW  = 32;

  // Select width for a given element count; a single element still gets one select bit.
  function automatic int sel_width(input int num_pes);
    return (num_pes > 1) ? $clog2(num_pes) : 1;
  endfunction

  // Pull element 'sel' (dw bits wide) out of a packed element vector.
  // Result is {range_error, element}; an out-of-range select yields error=1 and data 0.
  function automatic logic [MAX_DW:0] extract_lane(
    input logic [MAX_PES*MAX_DW-1:0] data,
    input logic [31:0]               sel,
    input logic [31:0]               num_pes,
    input logic [31:0]               dw
  );
    logic [MAX_PES*MAX_DW-1:0] shifted;
    logic [MAX_DW-1:0]         mask;
    shifted = data >> (sel * dw);
    mask    = ~({MAX_DW{1'b1}} << dw);
    if (sel >= num_pes) begin
      extract_lane = {1'b1, {MAX_DW{1'b0}}};
    end else begin
      extract_lane = {1'b0, shifted[MAX_DW-1:0] & mask};
    end
  endfunction

endpackage

// File: rtl/mux_pipe_stage.sv
// One valid/ready register stage. It loads whenever it is empty or the stage
// after it is taking its current contents, so bubbles collapse under stall.
module mux_pipe_stage #(
  parameter int WIDTH = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             up_ready,
  output logic             down_valid,
  output logic [WIDTH-1:0] down_data,
  input  logic             down_ready
);

  assign up_ready = !down_valid || down_ready;

  // Valid bit follows the upstream valid whenever this stage is enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      down_valid <= 1'b0;
    end else if (up_ready) begin
      down_valid <= up_valid;
    end
  end

  // Payload only captures real beats, so outputs stay at zero after reset until the first beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      down_data <= '0;
    end else if (up_ready && up_valid) begin
      down_data <= up_data;
    end
  end

endmodule

// File: rtl/pipelined_crossbar_mux.sv
// Multi-lane element selector for the PE result bus. Each lane picks one element,
// the selected lanes plus range-error flags travel through a valid/ready register chain,
// and completed output transfers are counted with saturation.
module pipelined_crossbar_mux
  import pe_mux_pkg::*;
#(
  parameter int NUM_PES     = 16,
  parameter int DATA_TYPE   = 8,
  parameter int NUM_OUT     = 4,
  parameter int NUM_SEL     = sel_width(NUM_PES),
  parameter int PIPE_STAGES = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_OUT*NUM_SEL-1:0]     sel_in,
  input  logic [NUM_PES*DATA_TYPE-1:0]   data_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_OUT*DATA_TYPE-1:0]   data_out,
  output logic [NUM_OUT-1:0]             sel_err,
  output logic [BEAT_CNT_W-1:0]          beat_count
);

  // Each lane carries {error, element} through the pipeline.
  localparam int LANE_W = DATA_TYPE + 1;
  localparam int PAY_W  = NUM_OUT * LANE_W;

  logic [MAX_PES*MAX_DW-1:0]                     data_ext;
  logic [NUM_OUT-1:0][MAX_DW:0]                  lane_raw;
  logic [NUM_OUT-1:0][MAX_DW-DATA_TYPE-1:0]      lane_spare_unused;
  logic [PAY_W-1:0]                              stage_in;
  logic [PAY_W-1:0]                              last_data;

  // Per-lane element selection with range checking, packed into the stage payload.
  always_comb begin
    data_ext                          = '0;
    data_ext[NUM_PES*DATA_TYPE-1:0]   = data_in;
    stage_in                          = '0;
    lane_raw                          = '0;
    lane_spare_unused                 = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      lane_raw[i] = extract_lane(data_ext, 32'(sel_in[i*NUM_SEL +: NUM_SEL]),
                                 32'(NUM_PES), 32'(DATA_TYPE));
      lane_spare_unused[i] = lane_raw[i][MAX_DW-1:DATA_TYPE];
      stage_in[i*LANE_W +: LANE_W] = {lane_raw[i][MAX_DW], lane_raw[i][DATA_TYPE-1:0]};
    end
  end

  // Register chain; ready ripples back from out_ready to in_ready with no skid buffer.
  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
    logic             up_valid;
    logic             up_ready;
    logic [PAY_W-1:0] up_data;
    logic             down_valid;
    logic             down_ready;
    logic [PAY_W-1:0] down_data;

    if (s == 0) begin : g_first
      assign up_valid = in_valid;
      assign up_data  = stage_in;
    end else begin : g_next
      assign up_valid = g_stage[s-1].down_valid;
      assign up_data  = g_stage[s-1].down_data;
    end

    if (s == PIPE_STAGES - 1) begin : g_tail
      assign down_ready = out_ready;
    end else begin : g_body
      assign down_ready = g_stage[s+1].up_ready;
    end

    mux_pipe_stage #(.WIDTH(PAY_W)) u_stage (
      .clk        (clk),
      .rst        (rst),
      .up_valid   (up_valid),
      .up_data    (up_data),
      .up_ready   (up_ready),
      .down_valid (down_valid),
      .down_data  (down_data),
      .down_ready (down_ready)
    );
  end

  assign in_ready  = g_stage[0].up_ready;
  assign out_valid = g_stage[PIPE_STAGES-1].down_valid;
  assign last_data = g_stage[PIPE_STAGES-1].down_data;

  // Outputs are plain slices of the last-stage register.
  always_comb begin
    data_out = '0;
    sel_err  = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      data_out[i*DATA_TYPE +: DATA_TYPE] = last_data[i*LANE_W +: DATA_TYPE];
      sel_err[i]                         = last_data[i*LANE_W + DATA_TYPE];
    end
  end

  // Count completed output transfers, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_count <= '0;
    end else if (out_valid && out_ready && (beat_count != '1)) begin
      beat_count <= beat_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipelined_crossbar_mux.sv
// Bench for pipelined_crossbar_mux: directed vector table streamed through the
// default instance, a scoreboard monitor, and hand-written multi-cycle corner cases.
module tb_pipelined_crossbar_mux;

  typedef struct packed {
    logic [7:0]  base;
    logic [15:0] sel;
    logic [31:0] exp;
  } vec_t;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  e;
  } beat_t;

  logic         clk, rst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [15:0]  sel_in;
  logic [127:0] data_in;
  logic [31:0]  data_out;
  logic [3:0]   sel_err;
  logic [15:0]  beat_count;

  logic         in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [15:0]  sel_in_b;
  logic [95:0]  data_in_b;
  logic [31:0]  data_out_b;
  logic [3:0]   sel_err_b;
  logic [15:0]  beat_count_b;

  vec_t        vtab [8];
  beat_t       exp_q [$];
  logic [31:0] exp_data_cur;
  logic [3:0]  exp_err_cur;
  int          tests, fails;
  int          occ, cyc, xfer_n, first_xfer, last_xfer;
  logic        stall_prev, chk_ready, bp_done;
  logic [31:0] held;

  pipelined_crossbar_mux dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sel_in(sel_in), .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .sel_err(sel_err), .beat_count(beat_count)
  );

  pipelined_crossbar_mux #(.NUM_PES(12)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .sel_in(sel_in_b), .data_in(data_in_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .data_out(data_out_b), .sel_err(sel_err_b), .beat_count(beat_count_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic logic [127:0] make_data(input logic [7:0] base);
    logic [127:0] d;
    for (int k = 0; k < 16; k++) d[k*8 +: 8] = base + 8'(k);
    return d;
  endfunction

  function automatic logic [31:0] ref_lanes(input logic [127:0] d, input logic [15:0] s);
    logic [31:0] r;
    int idx;
    for (int i = 0; i < 4; i++) begin
      idx = int'(s[i*4 +: 4]);
      r[i*8 +: 8] = 8'(d >> (idx * 8));
    end
    return r;
  endfunction

  // Present one beat on the default instance and hold it until accepted (bounded).
  task automatic applyStimulus(input logic [127:0] d, input logic [15:0] s,
                               input logic [31:0] e, input logic [3:0] er);
    int n;
    data_in      = d;
    sel_in       = s;
    exp_data_cur = e;
    exp_err_cur  = er;
    in_valid     = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) begin
      tests++;
      fails++;
      $display("[TB] FAIL accept_timeout: in_ready stayed 0, required 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Scoreboard monitor: ordered beat compare, stall hold, in_ready against an occupancy model.
  always @(negedge clk) begin
    beat_t b;
    int    acc, xfr;
    cyc++;
    if (rst) begin
      exp_q.delete();
      occ        = 0;
      stall_prev = 1'b0;
    end else begin
      if (chk_ready) checkOutput("in_ready_model", 32'(in_ready), 32'((occ < 2) || out_ready));
      if (stall_prev) begin
        checkOutput("stall_valid", 32'(out_valid), 32'd1);
        checkOutput("stall_data", data_out, held);
      end
      acc = (in_valid && in_ready) ? 1 : 0;
      xfr = (out_valid && out_ready) ? 1 : 0;
      if (xfr == 1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_beat: got %h, expected no beat", data_out);
        end else begin
          b = exp_q.pop_front();
          checkOutput("beat_data", data_out, b.d);
          checkOutput("beat_err", 32'(sel_err), 32'(b.e));
        end
        xfer_n++;
        if (xfer_n == 1) first_xfer = cyc;
        last_xfer = cyc;
      end
      stall_prev = out_valid && !out_ready;
      held       = data_out;
      if (acc == 1) exp_q.push_back(beat_t'({exp_data_cur, exp_err_cur}));
      occ = occ + acc - xfr;
    end
  end

  initial begin
    logic [127:0] d;
    logic [15:0]  s;

    vtab[0] = '{8'h10, 16'h7F30, 32'h171F1310};
    vtab[1] = '{8'h00, 16'h4321, 32'h04030201};
    vtab[2] = '{8'hF0, 16'h00FF, 32'hF0F0FFFF};
    vtab[3] = '{8'h80, 16'hBA98, 32'h8B8A8988};
    vtab[4] = '{8'hFA, 16'hF765, 32'h090100FF};
    vtab[5] = '{8'h33, 16'h0C0C, 32'h333F333F};
    vtab[6] = '{8'h40, 16'h12DE, 32'h41424D4E};
    vtab[7] = '{8'hC0, 16'h6666, 32'hC6C6C6C6};

    tests = 0; fails = 0; occ = 0; cyc = 0; xfer_n = 0; first_xfer = 0; last_xfer = 0;
    stall_prev = 1'b0; chk_ready = 1'b0; bp_done = 1'b0; held = '0;
    exp_data_cur = '0; exp_err_cur = '0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sel_in = '0; data_in = '0;
    in_valid_b = 1'b0; out_ready_b = 1'b1; sel_in_b = '0;
    for (int k = 0; k < 12; k++) data_in_b[k*8 +: 8] = 8'h10 + 8'(k);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_data_out", data_out, 32'd0);
    checkOutput("rst_sel_err", 32'(sel_err), 32'd0);
    checkOutput("rst_beat_count", 32'(beat_count), 32'd0);
    @(posedge clk);
    #1;

    // Single beat: latency of two stages
    applyStimulus(make_data(8'h10), 16'h7F30, 32'h171F1310, 4'h0);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("lat_early_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    checkOutput("lat_valid", 32'(out_valid), 32'd1);
    checkOutput("lat_data", data_out, 32'h171F1310);
    checkOutput("lat_err", 32'(sel_err), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("basic_count", 32'(beat_count), 32'd1);
    @(posedge clk);
    #1;

    // Vector table streamed back to back
    for (int i = 0; i < 8; i++) applyStimulus(make_data(vtab[i].base), vtab[i].sel, vtab[i].exp, 4'h0);
    in_valid = 1'b0;
    waitDrain();
    @(negedge clk);
    checkOutput("table_count", 32'(beat_count), 32'd9);
    @(posedge clk);
    #1;

    // 20-beat stream at full rate
    resetDut();
    xfer_n = 0;
    for (int j = 0; j < 20; j++) begin
      d = make_data(8'(j * 7));
      s = {4'(j / 4), 4'(15 - j), 4'(j + 5), 4'(j)};
      applyStimulus(d, s, ref_lanes(d, s), 4'h0);
    end
    in_valid = 1'b0;
    waitDrain();
    @(negedge clk);
    checkOutput("stream_count", 32'(beat_count), 32'd20);
    checkOutput("stream_xfers", 32'(xfer_n), 32'd20);
    checkOutput("stream_back2back", 32'(last_xfer - first_xfer), 32'd19);
    @(posedge clk);
    #1;

    // Backpressure with out_ready pattern 1,0,0,1
    xfer_n = 0;
    chk_ready = 1'b1;
    bp_done = 1'b0;
    fork
      begin
        for (int j = 0; j < 12; j++) begin
          d = make_data(8'(8'h50 + j * 3));
          s = {4'(j), 4'(j + 1), 4'(j * 5), 4'(~j)};
          applyStimulus(d, s, ref_lanes(d, s), 4'h0);
        end
        in_valid = 1'b0;
        bp_done = 1'b1;
      end
      begin
        int k;
        k = 0;
        while (!bp_done && k < 400) begin
          out_ready = ((k % 4) == 0) || ((k % 4) == 3);
          @(posedge clk);
          #1;
          k++;
        end
      end
    join
    out_ready = 1'b1;
    waitDrain();
    checkOutput("bp_xfers", 32'(xfer_n), 32'd12);
    chk_ready = 1'b0;

    // Out-of-range selects on the 12-element instance
    in_valid_b = 1'b1;
    sel_in_b = 16'h0BD2;
    @(negedge clk);
    checkOutput("oor_in_ready", 32'(in_ready_b), 32'd1);
    @(posedge clk);
    #1;
    sel_in_b = 16'h00CB;
    @(negedge clk);
    checkOutput("oor_early_valid", 32'(out_valid_b), 32'd0);
    @(posedge clk);
    #1;
    in_valid_b = 1'b0;
    @(negedge clk);
    checkOutput("oor_a_valid", 32'(out_valid_b), 32'd1);
    checkOutput("oor_a_data", data_out_b, 32'h101B0012);
    checkOutput("oor_a_err", 32'(sel_err_b), 32'b0010);
    @(negedge clk);
    checkOutput("oor_b_valid", 32'(out_valid_b), 32'd1);
    checkOutput("oor_b_data", data_out_b, 32'h1010001B);
    checkOutput("oor_b_err", 32'(sel_err_b), 32'b0010);
    @(negedge clk);
    checkOutput("oor_count", 32'(beat_count_b), 32'd2);
    @(posedge clk);
    #1;

    // Reset with two beats in flight
    out_ready = 1'b0;
    applyStimulus(make_data(vtab[1].base), vtab[1].sel, vtab[1].exp, 4'h0);
    applyStimulus(make_data(vtab[2].base), vtab[2].sel, vtab[2].exp, 4'h0);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("mid_valid_before", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_async_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_async_data", data_out, 32'd0);
    checkOutput("mid_async_count", 32'(beat_count), 32'd0);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("mid_no_stale", 32'(out_valid), 32'd0);
    end
    checkOutput("mid_in_ready", 32'(in_ready), 32'd1);
    checkOutput("mid_count", 32'(beat_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
